// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer: multi-cycle adder/subtractor sharing one 4-bit CLA slice, LSB nibble first
module cla_slice_sequencer #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic [3:0]       cla_a,
   output logic [3:0]       cla_b,
   output logic             cla_cin,
   input  logic [3:0]       cla_sum,
   input  logic             cla_cout,
   output logic             cla_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);
   localparam int NSLICE = WIDTH / 4;
   localparam int CW = $clog2(NSLICE);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_nx;
   logic carry;
   logic [CW-1:0] idx;
   logic run, last;
   assign run = state == RUN;
   assign last = idx == CW'(NSLICE - 1);
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // next state, CLA drive (zeroed outside RUN to avoid toggling) and status flags
   always_comb begin
      sum_nx = sum_reg;
      sum_nx[{idx, 2'b00} +: 4] = cla_sum;
      state_nx = (state == IDLE && in_valid) ? RUN :
                 (run && last) ? DONE :
                 (state == DONE && out_ready) ? IDLE : state;
      cla_en = run;
      cla_a = run ? a_reg[{idx, 2'b00} +: 4] : 4'd0;
      cla_b = run ? b_reg[{idx, 2'b00} +: 4] : 4'd0;
      cla_cin = run & carry;
      in_ready = state == IDLE;
      out_valid = state == DONE;
      busy = state != IDLE;
   end
   // operand capture, per-slice accumulation and result registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         sum_reg <= '0;
         carry <= 1'b0;
         idx <= '0;
         out_sum <= '0;
         out_cout <= 1'b0;
         out_ovf <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_reg <= in_a;
         b_reg <= in_sub ? ~in_b : in_b;
         carry <= in_sub;
         idx <= '0;
      end else if (run) begin
         sum_reg <= sum_nx;
         carry <= cla_cout;
         idx <= idx + 1'b1;
         if (last) begin
            out_sum <= sum_nx;
            out_cout <= cla_cout;
            out_ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_sum[3] != a_reg[WIDTH-1]);
         end
      end
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// tb_cla_slice_sequencer: directed checks of the sliced adder with a combinational CLA model
module tb_cla_slice_sequencer;
   logic clk, rst, in_valid, in_ready, in_sub, cla_cin, cla_cout, cla_en;
   logic out_valid, out_ready, out_cout, out_ovf, busy;
   logic [23:0] in_a, in_b, out_sum, prev_sum;
   logic [3:0] cla_a, cla_b, cla_sum;
   int tests, failed, n;

   cla_slice_sequencer #(.WIDTH(24)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin), .cla_sum(cla_sum),
      .cla_cout(cla_cout), .cla_en(cla_en), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
      .out_ovf(out_ovf), .busy(busy)
   );

   assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic sub, input logic [3:0] first_b, input logic [23:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf, input int hold);
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".cla_en"}, 32'(cla_en), 32'd1);
      chk({tag, ".cla_cin0"}, 32'(cla_cin), 32'(sub));
      chk({tag, ".cla_a0"}, 32'(cla_a), 32'(a[3:0]));
      chk({tag, ".cla_b0"}, 32'(cla_b), 32'(first_b));
      chk({tag, ".run_held"}, 32'(out_sum), 32'(prev_sum));
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".latency"}, 32'(n), 32'd6);
      chk({tag, ".sum"}, 32'(out_sum), 32'(exp_sum));
      chk({tag, ".cout"}, 32'(out_cout), 32'(exp_cout));
      chk({tag, ".ovf"}, 32'(out_ovf), 32'(exp_ovf));
      chk({tag, ".cla_en_done"}, 32'(cla_en), 32'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid = (i == 1);
         in_a = 24'hABCDEF; in_b = 24'h111111;
         @(negedge clk);
         chk({tag, ".bp_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".bp_ready"}, 32'(in_ready), 32'd0);
         chk({tag, ".bp_sum"}, 32'(out_sum), 32'(exp_sum));
         chk({tag, ".bp_cout"}, 32'(out_cout), 32'(exp_cout));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
      chk({tag, ".idle_sum"}, 32'(out_sum), 32'(exp_sum));
      prev_sum = exp_sum;
   endtask

   initial begin
      tests = 0; failed = 0;
      rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; prev_sum = '0;
      #12;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_sum", 32'(out_sum), 32'd0);
      chk("rst.cla", 32'({cla_en, cla_cin, cla_a, cla_b}), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("add1", 24'h000001, 24'h000001, 1'b0, 4'h1, 24'h000002, 1'b0, 1'b0, 0);
      run_op("carry", 24'hFFFFFF, 24'h000001, 1'b0, 4'h1, 24'h000000, 1'b1, 1'b0, 0);
      run_op("sub57", 24'h000005, 24'h000007, 1'b1, 4'h8, 24'hFFFFFE, 1'b0, 1'b0, 0);
      run_op("ovfadd", 24'h7FFFFF, 24'h000001, 1'b0, 4'h1, 24'h800000, 1'b0, 1'b1, 0);
      run_op("ovfsub", 24'h800000, 24'h000001, 1'b1, 4'hE, 24'h7FFFFF, 1'b1, 1'b1, 0);
      run_op("bp", 24'h00000A, 24'h000005, 1'b0, 4'h5, 24'h00000F, 1'b0, 1'b0, 3);
      run_op("afterbp", 24'h0A0A0A, 24'h050505, 1'b0, 4'h5, 24'h0F0F0F, 1'b0, 1'b0, 0);

      @(negedge clk);
      in_a = 24'h0F0F0F; in_b = 24'h010101; in_sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst.in_ready", 32'(in_ready), 32'd1);
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.cla", 32'({cla_en, cla_cin, cla_a, cla_b}), 32'd0);
      chk("midrst.out", 32'({out_valid, out_cout, out_ovf}), 32'd0);
      chk("midrst.out_sum", 32'(out_sum), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      prev_sum = '0;
      run_op("postrst", 24'h123456, 24'h111111, 1'b0, 4'h1, 24'h234567, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
